// File: rtl/hpi_pkg.sv
// Shared types and constants for the CY7C67200 host-port-interface access sequencer.
package hpi_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;

  localparam logic [ADDR_W-1:0] HPI_DATA    = 2'd0;
  localparam logic [ADDR_W-1:0] HPI_MAILBOX = 2'd1;
  localparam logic [ADDR_W-1:0] HPI_ADDRESS = 2'd2;
  localparam logic [ADDR_W-1:0] HPI_STATUS  = 2'd3;

  localparam int unsigned DEF_SETUP_CYC    = 1;
  localparam int unsigned DEF_STROBE_CYC   = 4;
  localparam int unsigned DEF_HOLD_CYC     = 1;
  localparam int unsigned DEF_RECOVER_CYC  = 2;
  localparam int unsigned DEF_RST_CYC      = 16;
  localparam int unsigned DEF_RST_WAIT_CYC = 32;

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, RECOVER, RST_PULSE, RST_WAIT
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } hpi_req_t;

  // Phase counters count N-1 down to 0, so a phase of N cycles loads N-1.
  function automatic logic [CNT_W-1:0] cyc_load(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/hpi_rr_arbiter.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
module hpi_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant_c
);

  // Index of the last granted requester; resets to 1 so requester 0 wins the first tie.
  logic last;

  always_comb begin
    grant_c = 2'b00;
    if (req[0] && req[1]) grant_c = last ? 2'b01 : 2'b10;
    else if (req[0])      grant_c = 2'b01;
    else if (req[1])      grant_c = 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last <= 1'b1;
    else if (advance && (grant_c != 2'b00)) last <= grant_c[1];
  end

endmodule

// File: rtl/hpi_access_sequencer.sv
// Timed HPI read/write/reset sequencer shared by two requesters.
module hpi_access_sequencer
  import hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC    = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC   = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
  parameter int unsigned RECOVER_CYC  = DEF_RECOVER_CYC,
  parameter int unsigned RST_CYC      = DEF_RST_CYC,
  parameter int unsigned RST_WAIT_CYC = DEF_RST_WAIT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              rst_req,
  output logic              busy,
  output logic [ADDR_W-1:0] otg_addr,
  output logic              otg_cs_n,
  output logic              otg_rd_n,
  output logic              otg_wr_n,
  output logic              otg_rst_n,
  output logic [DATA_W-1:0] otg_data_out,
  output logic              otg_data_oe,
  input  logic [DATA_W-1:0] otg_data_in
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  hpi_req_t         cur;
  logic             cur_port;
  logic             rst_pend;
  logic [1:0]       grant_c;
  logic             cnt_zero_c;
  logic             decide_c;
  logic             do_rst_c;
  logic             take_c;

  // Arbitration points: plain IDLE (not the accept cycle) and the last cycle of RECOVER/RST_WAIT.
  assign cnt_zero_c = (cnt == '0);
  assign decide_c   = ((state == IDLE) && !req0_ready && !req1_ready) ||
                      ((state == RECOVER) && cnt_zero_c) ||
                      ((state == RST_WAIT) && cnt_zero_c);
  assign do_rst_c   = rst_req || rst_pend;
  assign take_c     = decide_c && !do_rst_c && (grant_c != 2'b00);

  hpi_rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .advance (take_c),
    .grant_c (grant_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cur          <= '0;
      cur_port     <= 1'b0;
      rst_pend     <= 1'b0;
      req0_ready   <= 1'b0;
      req1_ready   <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp_rdata    <= '0;
      busy         <= 1'b0;
      otg_addr     <= '0;
      otg_cs_n     <= 1'b1;
      otg_rd_n     <= 1'b1;
      otg_wr_n     <= 1'b1;
      otg_rst_n    <= 1'b1;
      otg_data_out <= '0;
      otg_data_oe  <= 1'b0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      // A reset request seen during an access is remembered until the next arbitration point.
      if (rst_req && (state != RST_PULSE) && (state != RST_WAIT)) rst_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            state       <= SETUP;
            busy        <= 1'b1;
            cnt         <= cyc_load(SETUP_CYC);
            otg_cs_n    <= 1'b0;
            otg_addr    <= cur.addr;
            otg_data_oe <= cur.write;
            if (cur.write) otg_data_out <= cur.wdata;
          end
        end
        SETUP: begin
          if (cnt_zero_c) begin
            state    <= STROBE;
            cnt      <= cyc_load(STROBE_CYC);
            otg_rd_n <= cur.write;
            otg_wr_n <= !cur.write;
          end else cnt <= cnt - 1'b1;
        end
        STROBE: begin
          if (cnt_zero_c) begin
            state    <= HOLD;
            cnt      <= cyc_load(HOLD_CYC);
            otg_rd_n <= 1'b1;
            otg_wr_n <= 1'b1;
            if (!cur.write) rsp_rdata <= otg_data_in;
          end else cnt <= cnt - 1'b1;
        end
        HOLD: begin
          if (cnt_zero_c) begin
            state       <= RECOVER;
            cnt         <= cyc_load(RECOVER_CYC);
            otg_cs_n    <= 1'b1;
            otg_data_oe <= 1'b0;
            rsp0_valid  <= !cur_port;
            rsp1_valid  <= cur_port;
          end else cnt <= cnt - 1'b1;
        end
        RECOVER, RST_WAIT: begin
          if (!cnt_zero_c) cnt <= cnt - 1'b1;
        end
        RST_PULSE: begin
          if (cnt_zero_c) begin
            state     <= RST_WAIT;
            cnt       <= cyc_load(RST_WAIT_CYC);
            otg_rst_n <= 1'b1;
          end else cnt <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (decide_c) begin
        state <= IDLE;
        busy  <= 1'b0;
        if (do_rst_c) begin
          state     <= RST_PULSE;
          busy      <= 1'b1;
          cnt       <= cyc_load(RST_CYC);
          otg_rst_n <= 1'b0;
          rst_pend  <= 1'b0;
        end else if (grant_c[0]) begin
          req0_ready <= 1'b1;
          cur_port   <= 1'b0;
          cur        <= '{write: req0_write, addr: req0_addr, wdata: req0_wdata};
        end else if (grant_c[1]) begin
          req1_ready <= 1'b1;
          cur_port   <= 1'b1;
          cur        <= '{write: req1_write, addr: req1_addr, wdata: req1_wdata};
        end
      end
    end
  end

endmodule

// File: tb/tb_hpi_access_sequencer.sv
// Self-checking bench: vector table for pin timing, response scoreboard, hand sequences for corner cases.
module tb_hpi_access_sequencer;
  import hpi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              req0_valid, req0_write, req0_ready, rsp0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid, req1_write, req1_ready, rsp1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rst_req, busy;
  logic [ADDR_W-1:0] otg_addr;
  logic              otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n, otg_data_oe;
  logic [DATA_W-1:0] otg_data_out, otg_data_in;

  logic              req0_valid_f;
  logic              req0_ready_f, rsp0_valid_f, req1_ready_f, rsp1_valid_f, busy_f;
  logic [DATA_W-1:0] rsp_rdata_f, otg_data_out_f;
  logic [ADDR_W-1:0] otg_addr_f;
  logic              otg_cs_n_f, otg_rd_n_f, otg_wr_n_f, otg_rst_n_f, otg_data_oe_f;

  hpi_access_sequencer dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp_rdata(rsp_rdata), .rst_req(rst_req), .busy(busy),
    .otg_addr(otg_addr), .otg_cs_n(otg_cs_n), .otg_rd_n(otg_rd_n), .otg_wr_n(otg_wr_n),
    .otg_rst_n(otg_rst_n), .otg_data_out(otg_data_out), .otg_data_oe(otg_data_oe),
    .otg_data_in(otg_data_in)
  );

  hpi_access_sequencer #(
    .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .RECOVER_CYC(1)
  ) dut_fast (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid_f), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready_f), .rsp0_valid(rsp0_valid_f),
    .req1_valid(1'b0), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready_f), .rsp1_valid(rsp1_valid_f),
    .rsp_rdata(rsp_rdata_f), .rst_req(1'b0), .busy(busy_f),
    .otg_addr(otg_addr_f), .otg_cs_n(otg_cs_n_f), .otg_rd_n(otg_rd_n_f), .otg_wr_n(otg_wr_n_f),
    .otg_rst_n(otg_rst_n_f), .otg_data_out(otg_data_out_f), .otg_data_oe(otg_data_oe_f),
    .otg_data_in(otg_data_in)
  );

  typedef struct {
    logic              port;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic              port;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_vals();
    chkb("rst_cs_n", otg_cs_n, 1'b1);
    chkb("rst_rd_n", otg_rd_n, 1'b1);
    chkb("rst_wr_n", otg_wr_n, 1'b1);
    chkb("rst_rst_n", otg_rst_n, 1'b1);
    chkb("rst_oe", otg_data_oe, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_ready", req0_ready || req1_ready, 1'b0);
    chkb("rst_rsp", rsp0_valid || rsp1_valid, 1'b0);
    chkw("rst_addr", 16'(otg_addr), 16'h0);
    chkw("rst_data_out", otg_data_out, 16'h0);
    chkw("rst_rdata", rsp_rdata, 16'h0);
  endtask

  task automatic set_req(input vec_t v);
    if (v.port) begin
      req1_write = v.write; req1_addr = v.addr; req1_wdata = v.wdata; req1_valid = 1'b1;
    end else begin
      req0_write = v.write; req0_addr = v.addr; req0_wdata = v.wdata; req0_valid = 1'b1;
    end
  endtask

  task automatic wait_ready(input logic port, output logic got);
    got = 1'b0;
    for (int w = 0; w < 100 && !got; w++) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) got = 1'b1;
    end
    chkb("ready_wait", got, 1'b1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int w = 0; w < 200 && !done; w++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1'b1;
    end
    chkb("drain", done, 1'b1);
  endtask

  // One access with default timing; pins checked cycle by cycle against the accept cycle t.
  task automatic run_access(input vec_t v);
    logic got, drive, strobe;
    set_req(v);
    otg_data_in = v.din;
    wait_ready(v.port, got);
    sb.push_back('{port: v.port, rdata: v.exp_rdata});
    if (v.port) req1_valid = 1'b0; else req0_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      drive  = (k <= 6);
      strobe = (k >= 2 && k <= 5);
      chkb("cs_n", otg_cs_n, !drive);
      chkb("wr_n", otg_wr_n, !(strobe && v.write));
      chkb("rd_n", otg_rd_n, !(strobe && !v.write));
      chkb("data_oe", otg_data_oe, drive && v.write);
      chkb("busy", busy, 1'b1);
      chkb("rsp_valid_time", v.port ? rsp1_valid : rsp0_valid, k == 7);
      if (drive) chkw("addr", 16'(otg_addr), 16'(v.addr));
      if (drive && v.write) chkw("data_out", otg_data_out, v.wdata);
    end
  endtask

  // Response scoreboard.
  always @(negedge clk) begin
    if (rsp0_valid || rsp1_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rsp0=%0b rsp1=%0b expected no response (cycle %0d)",
                 rsp0_valid, rsp1_valid, cyc);
      end else begin
        mon_e = sb.pop_front();
        chkb("rsp_port", rsp1_valid, mon_e.port);
        chkb("rsp_one_hot", rsp0_valid && rsp1_valid, 1'b0);
        chkw("rsp_rdata", rsp_rdata, mon_e.rdata);
      end
    end
  end

  // Pin-level safety checks every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chkb("strobe_overlap", !otg_rd_n && !otg_wr_n, 1'b0);
      chkb("oe_during_read", otg_data_oe && !otg_rd_n, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    int   last_cyc;
    vecs[0] = '{1'b0, 1'b1, HPI_ADDRESS, 16'h1234, 16'h5555, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, HPI_DATA,    16'h0000, 16'hBEEF, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, HPI_STATUS,  16'hA5A5, 16'h1111, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b0, HPI_MAILBOX, 16'h0000, 16'h0F0F, 16'h0F0F};
    vecs[4] = '{1'b0, 1'b1, HPI_DATA,    16'hFFFF, 16'h2222, 16'h0F0F};
    vecs[5] = '{1'b1, 1'b0, HPI_STATUS,  16'h0000, 16'h8001, 16'h8001};

    rst = 1'b1; rst_req = 1'b0; otg_data_in = 16'h0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    req0_valid_f = 1'b0;
    #12;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals();

    // Both requesters held valid: grants alternate 0,1,0,1 nine cycles apart.
    req0_write = 1'b1; req0_addr = HPI_DATA;    req0_wdata = 16'h0A0A;
    req1_write = 1'b1; req1_addr = HPI_MAILBOX; req1_wdata = 16'h0B0B;
    req0_valid = 1'b1; req1_valid = 1'b1;
    last_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      for (int w = 0; w < 30 && !got; w++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) got = 1'b1;
      end
      chkb("alt_ready_seen", got, 1'b1);
      chkb("alt_port", req1_ready, 1'(i % 2));
      chkb("alt_single_ready", req0_ready && req1_ready, 1'b0);
      if (i > 0) chkw("alt_spacing", 16'(cyc - last_cyc), 16'd9);
      last_cyc = cyc;
      sb.push_back('{port: req1_ready, rdata: 16'h0000});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    for (int i = 0; i < 6; i++) run_access(vecs[i]);
    wait_idle();

    // Reset request during a read: read finishes, then 16 low + 32 wait, then pending req0.
    set_req('{1'b0, 1'b0, HPI_MAILBOX, 16'h0000, 16'hC3C3, 16'hC3C3});
    otg_data_in = 16'hC3C3;
    wait_ready(1'b0, got);
    sb.push_back('{port: 1'b0, rdata: 16'hC3C3});
    req0_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      chkb("rst_pulse_n", otg_rst_n, !(k >= 9 && k <= 24));
      chkb("rst_gates_ready", req0_ready, k == 57);
      if (k == 1) begin
        req0_write = 1'b1; req0_addr = HPI_STATUS; req0_wdata = 16'h9999; req0_valid = 1'b1;
      end
      if (k == 3) rst_req = 1'b1;
      if (k == 4) rst_req = 1'b0;
      if (k == 57) begin
        sb.push_back('{port: 1'b0, rdata: 16'hC3C3});
        req0_valid = 1'b0;
      end
    end
    wait_idle();

    // Async reset during STROBE aborts the write with no response.
    set_req('{1'b0, 1'b1, HPI_MAILBOX, 16'h4321, 16'h0000, 16'h0000});
    wait_ready(1'b0, got);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    chkb("pre_abort_wr_n", otg_wr_n, 1'b0);
    #1 rst = 1'b1;
    #1 chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chkb("abort_busy", busy, 1'b0);
    chkw("abort_sb_empty", 16'(sb.size()), 16'd0);
    run_access('{1'b1, 1'b0, HPI_DATA, 16'h0000, 16'h7E7E, 16'h7E7E});
    wait_idle();

    // Minimum timing instance, requester kept valid for a back-to-back second access.
    req0_write = 1'b1; req0_addr = HPI_ADDRESS; req0_wdata = 16'h5A5A;
    req0_valid_f = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 30 && !got; w++) begin
      @(negedge clk);
      if (req0_ready_f) got = 1'b1;
    end
    chkb("fast_ready_wait", got, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chkb("fast_wr_n", otg_wr_n_f, !(k == 2 || k == 7));
      chkb("fast_cs_n", otg_cs_n_f, !((k >= 1 && k <= 3) || (k >= 6 && k <= 8)));
      chkb("fast_rsp", rsp0_valid_f, k == 4 || k == 9);
      chkb("fast_ready", req0_ready_f, k == 5);
      if (k == 5) req0_valid_f = 1'b0;
    end
    repeat (4) @(negedge clk);
    chkb("fast_idle", busy_f, 1'b0);

    chkw("sb_final_empty", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
